// File: rtl/spi_transaction_fsm.sv
// Transaction sequencer for an SPI peripheral. It steps through the address
// phase and the read or write data phase, and it emits the control strobes.
module spi_transaction_fsm #(
    parameter int WIDTH = 8  // SCLK edges per phase, 2..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipSelect,
    input  logic       peripheralClkEdge,
    input  logic       readWrite,
    output logic       addrLatchEnable,
    output logic       shiftRegParallelLoad,
    output logic       misoBufferEnable,
    output logic       dataMemWriteEnable,
    output logic [2:0] fsmState
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_WAIT   = 3'd3,
        READ_LOAD   = 3'd4,
        READ_SHIFT  = 3'd5,
        WRITE_SHIFT = 3'd6,
        WRITE_MEM   = 3'd7
    } state_t;

    typedef struct packed {
        logic addrLatch;
        logic parallelLoad;
        logic misoDrive;
        logic memWrite;
    } ctrl_t;

    localparam logic [3:0] LAST_EDGE = 4'(WIDTH - 1);

    state_t     state, stateNext;
    logic [3:0] edgeCount;
    logic       armed;
    logic       countPhase;
    logic       lastEdge;
    ctrl_t      ctrl;

    assign countPhase = (state == GET_ADDR) || (state == READ_SHIFT) || (state == WRITE_SHIFT);
    assign lastEdge   = peripheralClkEdge && (edgeCount == LAST_EDGE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Every state entry restarts the count. Edges are counted only in the shifting phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgeCount <= 4'd0;
        end else if (stateNext != state) begin
            edgeCount <= 4'd0;
        end else if (countPhase && peripheralClkEdge) begin
            edgeCount <= edgeCount + 4'd1;
        end
    end

    // A new transaction may start only after CS has been seen high. This keeps a
    // finished transaction from starting again while CS stays low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b1;
        end else if (chipSelect) begin
            armed <= 1'b1;
        end else if (state == IDLE && stateNext == GET_ADDR) begin
            armed <= 1'b0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:        if (!chipSelect && armed) stateNext = GET_ADDR;
            GET_ADDR:    if (lastEdge) stateNext = GOT_ADDR;
            GOT_ADDR:    stateNext = readWrite ? READ_WAIT : WRITE_SHIFT;
            READ_WAIT:   stateNext = READ_LOAD;
            READ_LOAD:   stateNext = READ_SHIFT;
            READ_SHIFT:  if (lastEdge) stateNext = IDLE;
            WRITE_SHIFT: if (lastEdge) stateNext = WRITE_MEM;
            WRITE_MEM:   stateNext = IDLE;
            default:     stateNext = IDLE;
        endcase
        // CS high overrides every transition, so an aborted write never reaches WRITE_MEM.
        if (chipSelect && state != IDLE) stateNext = IDLE;
    end

    always_comb begin
        ctrl = '0;
        case (state)
            GOT_ADDR:   ctrl.addrLatch    = 1'b1;
            READ_LOAD:  ctrl.parallelLoad = 1'b1;
            READ_SHIFT: ctrl.misoDrive    = 1'b1;
            WRITE_MEM:  ctrl.memWrite     = 1'b1;
            default:    ctrl = '0;
        endcase
    end

    assign addrLatchEnable      = ctrl.addrLatch;
    assign shiftRegParallelLoad = ctrl.parallelLoad;
    assign misoBufferEnable     = ctrl.misoDrive;
    assign dataMemWriteEnable   = ctrl.memWrite;
    assign fsmState             = state;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Scoreboard bench for spi_transaction_fsm. Each step queues the expected state and
// strobes, and each scenario task compares them with the captured DUT outputs.
module tb_spi_transaction_fsm;

    localparam int         W       = 8;
    localparam logic [2:0] S_IDLE  = 3'd0, S_GET = 3'd1, S_GOT = 3'd2, S_RWAIT = 3'd3;
    localparam logic [2:0] S_RLOAD = 3'd4, S_RSH = 3'd5, S_WSH = 3'd6, S_WMEM = 3'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipSelect = 1'b1;
    logic       peripheralClkEdge = 1'b0;
    logic       readWrite = 1'b0;
    logic       addrLatchEnable, shiftRegParallelLoad, misoBufferEnable, dataMemWriteEnable;
    logic [2:0] fsmState;

    logic [6:0] expQ[$];
    logic [6:0] obsQ[$];
    int         nChecks = 0;
    int         nFail = 0;

    spi_transaction_fsm #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .chipSelect(chipSelect),
        .peripheralClkEdge(peripheralClkEdge),
        .readWrite(readWrite),
        .addrLatchEnable(addrLatchEnable),
        .shiftRegParallelLoad(shiftRegParallelLoad),
        .misoBufferEnable(misoBufferEnable),
        .dataMemWriteEnable(dataMemWriteEnable),
        .fsmState(fsmState)
    );

    always #5 clk = ~clk;

    // Expected value: {state, ale, load, miso, wr}.
    function automatic logic [6:0] expVec(input logic [2:0] s);
        return {s, s == S_GOT, s == S_RLOAD, s == S_RSH, s == S_WMEM};
    endfunction

    task automatic step(input logic cs, input logic edg, input logic rw, input logic [2:0] s);
        chipSelect = cs;
        peripheralClkEdge = edg;
        readWrite = rw;
        expQ.push_back(expVec(s));
        @(posedge clk);
        #1;
        obsQ.push_back({fsmState, addrLatchEnable, shiftRegParallelLoad,
                        misoBufferEnable, dataMemWriteEnable});
        peripheralClkEdge = 1'b0;
    endtask

    // CS falls, optionally with an edge in the same clk, and then W edges.
    task automatic addrPhase(input logic rw, input logic firstEdge);
        step(1'b0, firstEdge, rw, S_GET);
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b0, rw, S_GET);
            step(1'b0, 1'b1, rw, (i == W) ? S_GOT : S_GET);
        end
    endtask

    task automatic test_reset;
        logic [6:0] e, o;
        if ({fsmState, addrLatchEnable, shiftRegParallelLoad, misoBufferEnable,
             dataMemWriteEnable} !== 7'd0) begin
            nFail++;
            $display("FAIL reset_init: got %b want %b", {fsmState, addrLatchEnable,
                     shiftRegParallelLoad, misoBufferEnable, dataMemWriteEnable}, 7'd0);
        end
        nChecks++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        step(1'b0, 1'b0, 1'b0, S_GET);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0, S_GET);
            step(1'b0, 1'b1, 1'b0, S_GET);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL reset_pre #%0d: got %b want %b", nChecks, o, e);
            end
        end
        // Reset is asserted between clock edges while CS stays low.
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if ({fsmState, addrLatchEnable, shiftRegParallelLoad, misoBufferEnable,
             dataMemWriteEnable} !== 7'd0) begin
            nFail++;
            $display("FAIL reset_async: got state %0d want 0", fsmState);
        end
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, S_GET);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL reset_release #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    task automatic test_write;
        logic [6:0] e, o;
        addrPhase(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, S_WSH);
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b0, 1'b0, S_WSH);
            step(1'b0, 1'b1, 1'b0, (i == W) ? S_WMEM : S_WSH);
        end
        step(1'b0, 1'b0, 1'b0, S_IDLE);
        // CS still low after completion: edges must not restart a transaction.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, S_IDLE);
        step(1'b0, 1'b0, 1'b0, S_IDLE);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        step(1'b0, 1'b0, 1'b0, S_GET);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL write #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    task automatic test_read;
        logic [6:0] e, o;
        addrPhase(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, S_RWAIT);
        step(1'b0, 1'b0, 1'b1, S_RLOAD);
        step(1'b0, 1'b0, 1'b1, S_RSH);
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b0, 1'b1, S_RSH);
            step(1'b0, 1'b1, 1'b1, (i == W) ? S_IDLE : S_RSH);
        end
        step(1'b0, 1'b1, 1'b1, S_IDLE);
        step(1'b1, 1'b0, 1'b1, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL read #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    task automatic test_abort;
        logic [6:0] e, o;
        addrPhase(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, S_WSH);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b0, S_WSH);
            step(1'b0, 1'b1, 1'b0, S_WSH);
        end
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        // CS rises in the same clk as the final data edge, so no memory write may follow.
        addrPhase(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, S_WSH);
        for (int i = 1; i < W; i++) begin
            step(1'b0, 1'b0, 1'b0, S_WSH);
            step(1'b0, 1'b1, 1'b0, S_WSH);
        end
        step(1'b0, 1'b0, 1'b0, S_WSH);
        step(1'b1, 1'b1, 1'b0, S_IDLE);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL abort #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    task automatic test_edge_with_cs;
        logic [6:0] e, o;
        addrPhase(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL edge_with_cs #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] e, o;
        addrPhase(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, S_RWAIT);
        step(1'b0, 1'b0, 1'b1, S_RLOAD);
        step(1'b0, 1'b0, 1'b1, S_RSH);
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b1, 1'b1, (i == W) ? S_IDLE : S_RSH);
        end
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        addrPhase(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, S_WSH);
        for (int i = 1; i <= W; i++) begin
            step(1'b0, 1'b1, 1'b0, (i == W) ? S_WMEM : S_WSH);
        end
        step(1'b0, 1'b0, 1'b0, S_IDLE);
        step(1'b1, 1'b0, 1'b0, S_IDLE);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = obsQ.pop_front();
            nChecks++;
            if (o !== e) begin
                nFail++;
                $display("FAIL back_to_back #%0d: got %b want %b", nChecks, o, e);
            end
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_edge_with_cs;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/spi_transaction_fsm.md
SPI_TRANSACTION_FSM -- requirements
Module: spi_transaction_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning SCLK edges per address phase and per data phase (legal range 2..15).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port chipSelect, input, 1, synchronized SPI CS, active-low; high ends any transaction.
REQ-005 SHALL have port peripheralClkEdge, input, 1, one-clk pulse per SCLK sampling (rising) edge, same pulse that drives the shift register.
REQ-006 SHALL have port readWrite, input, 1, shift register parallelDataOut[0]; 1 = read, 0 = write.
REQ-007 SHALL have port addrLatchEnable, output, 1, one-clk strobe loading the address latch from shift register.
REQ-008 SHALL have port shiftRegParallelLoad, output, 1, one-clk strobe loading shift register from data memory.
REQ-009 SHALL have port misoBufferEnable, output, 1, enables MISO tri-state driver.
REQ-010 SHALL have port dataMemWriteEnable, output, 1, one-clk data memory write strobe.
REQ-011 SHALL have port fsmState, output, 3, current state encoding (REQ-013).

Function
REQ-012 SHALL be a Moore FSM; all outputs decoded from registered state only.
REQ-013 SHALL use states IDLE=0, GET_ADDR=1, GOT_ADDR=2, READ_WAIT=3, READ_LOAD=4, READ_SHIFT=5, WRITE_SHIFT=6, WRITE_MEM=7; DONE is merged into IDLE semantics via REQ-022.
REQ-014 SHALL keep a 4-bit edge counter, cleared on every state entry, incremented by peripheralClkEdge only in GET_ADDR, READ_SHIFT, WRITE_SHIFT.
REQ-015 SHALL go IDLE -> GET_ADDR on a clk where chipSelect=0; a peripheralClkEdge in that same clk is not counted.
REQ-016 SHALL go GET_ADDR -> GOT_ADDR on the clk where the WIDTH-th edge is counted (counter reaching WIDTH).
REQ-017 SHALL stay in GOT_ADDR exactly 1 clk, asserting addrLatchEnable, then go READ_WAIT if readWrite=1, else WRITE_SHIFT.
REQ-018 SHALL stay in READ_WAIT 1 clk (memory read latency), then READ_LOAD for 1 clk asserting shiftRegParallelLoad, then READ_SHIFT.
REQ-019 SHALL assert misoBufferEnable only in READ_SHIFT; after WIDTH counted edges go to IDLE-wait (REQ-022).
REQ-020 SHALL, in WRITE_SHIFT, count WIDTH edges then go WRITE_MEM for 1 clk asserting dataMemWriteEnable, then IDLE-wait.
REQ-021 SHALL give chipSelect=1 priority over every transition: from any non-IDLE state, next state IDLE; a strobe pending that clk is suppressed (no write on abort mid-WRITE_SHIFT).
REQ-022 SHALL, after a completed transaction, remain in IDLE but not re-enter GET_ADDR until chipSelect has been observed high for at least 1 clk (armed flag, set when chipSelect=1, cleared on GET_ADDR entry).
REQ-023 SHALL ignore peripheralClkEdge in IDLE, GOT_ADDR, READ_WAIT, READ_LOAD, WRITE_MEM.
REQ-024 SHALL never assert more than one of the four control outputs in one clk.

Reset
REQ-025 SHALL on reset=1, immediately and independent of clk, force state IDLE, counter 0, armed flag 1, all control outputs 0, fsmState 0.
REQ-026 SHALL, on reset release mid-transaction, wait in IDLE for chipSelect=0 with armed=1 before starting.

Verification
REQ-027 SHALL pass: reset pulse with chipSelect=0 mid GET_ADDR -> fsmState=0, all outputs 0 asynchronously.
REQ-028 SHALL pass: CS low, 8 edges, readWrite=0, 8 edges -> addrLatchEnable 1 clk after 8th edge, dataMemWriteEnable exactly 1 clk after 16th edge, fsmState 1,2,6,7,0.
REQ-029 SHALL pass: CS low, 8 edges, readWrite=1 -> addrLatchEnable, then READ_WAIT, shiftRegParallelLoad 1 clk, misoBufferEnable high for 8 edges then 0.
REQ-030 SHALL pass: CS high after 5 edges of WRITE_SHIFT -> fsmState 0 next clk, dataMemWriteEnable never asserted.
REQ-031 SHALL pass: CS held low after complete write, further edges -> stays IDLE, no strobes; CS high 1 clk then low -> GET_ADDR.
REQ-032 SHALL pass: edge pulse in same clk as CS fall, then 8 more edges -> GOT_ADDR only after the 8 later edges.
